// File: rtl/axi_pkg.sv
// Shared AXI4 encodings and the write-burst transmitter FSM state type.
package axi_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_ADDR = 2'd1,
        TX_DATA = 2'd2,
        TX_RESP = 2'd3
    } tx_state_e;

endpackage

// File: rtl/axi_wr_burst_tx_if.sv
// FIFO-head and AXI4 write-channel bundle between the burst transmitter and its environment.
interface axi_wr_burst_tx_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LEN_WIDTH  = 8
);
    localparam int unsigned CMD_WIDTH  = ADDR_WIDTH + LEN_WIDTH;
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    logic                  cmd_empty;
    logic [CMD_WIDTH-1:0]  cmd_head;
    logic                  cmd_rd_en;
    logic                  dat_empty;
    logic [DATA_WIDTH-1:0] dat_head;
    logic                  dat_rd_en;

    logic [ADDR_WIDTH-1:0] awaddr;
    logic [LEN_WIDTH-1:0]  awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;
    logic                  awvalid;
    logic                  awready;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic                  wlast;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;

    modport master (
        input  cmd_empty, cmd_head, dat_empty, dat_head, awready, wready, bresp, bvalid,
        output cmd_rd_en, dat_rd_en, awaddr, awlen, awsize, awburst, awvalid,
               wdata, wstrb, wlast, wvalid, bready
    );

    modport slave (
        output cmd_empty, cmd_head, dat_empty, dat_head, awready, wready, bresp, bvalid,
        input  cmd_rd_en, dat_rd_en, awaddr, awlen, awsize, awburst, awvalid,
               wdata, wstrb, wlast, wvalid, bready
    );

endinterface

// File: rtl/axi_wr_burst_tx.sv
// AXI4 write-burst transmitter: pops {addr,len} and data beats from FIFO heads, issues one
// INCR burst at a time on AW/W and reports the B response.
module axi_wr_burst_tx
    import axi_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LEN_WIDTH  = 8
) (
    input  logic              clk,
    input  logic              clr,
    axi_wr_burst_tx_if.master bus,
    output logic              busy,
    output logic              burst_done,
    output logic              resp_err
);
    localparam int unsigned CMD_WIDTH  = ADDR_WIDTH + LEN_WIDTH;
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
    localparam logic [2:0]  AW_SIZE    = 3'($clog2(STRB_WIDTH));

    tx_state_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [LEN_WIDTH-1:0]  awlen_q, awlen_d;
    logic [LEN_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;

    logic cmd_rd_en, dat_rd_en, awvalid, wvalid, wlast, bready;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q    <= TX_IDLE;
            awaddr_q   <= '0;
            awlen_q    <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            awaddr_q   <= awaddr_d;
            awlen_q    <= awlen_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        awaddr_d   = awaddr_q;
        awlen_d    = awlen_q;
        beat_cnt_d = beat_cnt_q;
        cmd_rd_en  = 1'b0;
        dat_rd_en  = 1'b0;
        awvalid    = 1'b0;
        wvalid     = 1'b0;
        wlast      = 1'b0;
        bready     = 1'b0;
        burst_done = 1'b0;
        resp_err   = 1'b0;
        unique case (state_q)
            TX_IDLE: begin
                if (!bus.cmd_empty) begin
                    cmd_rd_en  = 1'b1;
                    awaddr_d   = bus.cmd_head[CMD_WIDTH-1:LEN_WIDTH];
                    awlen_d    = bus.cmd_head[LEN_WIDTH-1:0];
                    beat_cnt_d = '0;
                    state_d    = TX_ADDR;
                end
            end
            TX_ADDR: begin
                awvalid = 1'b1;
                if (bus.awready) state_d = TX_DATA;
            end
            TX_DATA: begin
                // The head only changes on a pop, so wvalid cannot fall once raised.
                wvalid = !bus.dat_empty;
                wlast  = (beat_cnt_q == awlen_q);
                if (wvalid && bus.wready) begin
                    dat_rd_en = 1'b1;
                    if (wlast) state_d = TX_RESP;
                    else       beat_cnt_d = beat_cnt_q + 1'b1;
                end
            end
            TX_RESP: begin
                bready = 1'b1;
                if (bus.bvalid) begin
                    burst_done = 1'b1;
                    resp_err   = bus.bresp[1];
                    state_d    = TX_IDLE;
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

    assign busy          = (state_q != TX_IDLE);
    assign bus.cmd_rd_en = cmd_rd_en;
    assign bus.dat_rd_en = dat_rd_en;
    assign bus.awaddr    = awaddr_q;
    assign bus.awlen     = awlen_q;
    assign bus.awsize    = AW_SIZE;
    assign bus.awburst   = AXI_BURST_INCR;
    assign bus.awvalid   = awvalid;
    assign bus.wdata     = bus.dat_head;
    assign bus.wstrb     = {STRB_WIDTH{1'b1}};
    assign bus.wlast     = wlast;
    assign bus.wvalid    = wvalid;
    assign bus.bready    = bready;

endmodule

// File: tb/tb_axi_wr_burst_tx.sv
// Bench for axi_wr_burst_tx: FIFO and AXI slave models with AW/W/B scoreboards.
module tb_axi_wr_burst_tx;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
        int          cycles;
    } aw_exp_t;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } w_exp_t;

    logic clk = 1'b0;
    logic clr = 1'b0;
    logic busy, burst_done, resp_err;

    axi_wr_burst_tx_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .LEN_WIDTH(8)) bus ();

    axi_wr_burst_tx #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .LEN_WIDTH(8)) dut (
        .clk        (clk),
        .clr        (clr),
        .bus        (bus.master),
        .busy       (busy),
        .burst_done (burst_done),
        .resp_err   (resp_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [39:0] cmd_q[$];
    logic [31:0] dat_q[$];
    logic [1:0]  resp_q[$];
    aw_exp_t     aw_exp[$];
    w_exp_t      w_exp[$];
    logic        b_exp[$];

    int   aw_stall = 0;
    logic wr_alt   = 1'b0;
    int   w_beats  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic refresh();
        bus.cmd_empty = (cmd_q.size() == 0);
        bus.cmd_head  = (cmd_q.size() != 0) ? cmd_q[0] : 40'd0;
        bus.dat_empty = (dat_q.size() == 0);
        bus.dat_head  = (dat_q.size() != 0) ? dat_q[0] : 32'd0;
    endtask

    task automatic push_cmd(input logic [31:0] addr, input logic [7:0] len);
        aw_exp_t e;
        e.addr = addr; e.len = len; e.cycles = aw_stall + 1;
        cmd_q.push_back({addr, len});
        aw_exp.push_back(e);
        refresh();
    endtask

    task automatic push_data(input logic [31:0] d, input logic last);
        w_exp_t e;
        e.data = d; e.last = last;
        dat_q.push_back(d);
        w_exp.push_back(e);
        refresh();
    endtask

    task automatic push_resp(input logic [1:0] r);
        resp_q.push_back(r);
        b_exp.push_back(r[1]);
    endtask

    task automatic push_burst(input logic [31:0] addr, input logic [7:0] len,
                              input logic [31:0] base, input logic [1:0] r);
        push_cmd(addr, len);
        for (int i = 0; i <= int'(len); i++) push_data(base + 32'(i), (i == int'(len)));
        push_resp(r);
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_done(input int max_cycles);
        int n = 0;
        while ((aw_exp.size() != 0 || w_exp.size() != 0 || b_exp.size() != 0 || busy ||
                cmd_q.size() != 0) && n < max_cycles) begin
            step();
            n++;
        end
        check("drain_timeout", 64'(n >= max_cycles), 64'd0);
    endtask

    // FIFO + AXI slave model: sample at negedge, update state just after posedge.
    initial begin : bfm
        logic        pop_cmd, pop_dat, aw_hs, w_hs, b_hs, b_pend, w_phase, w_tog;
        logic        aw_pend, w_pend;
        logic [40:0] aw_vec;
        logic [40:0] w_vec;
        int          aw_cyc, aw_wait;
        aw_exp_t     ae;
        w_exp_t      we;
        logic        be;
        pop_cmd = 0; pop_dat = 0; b_pend = 0; w_phase = 0; w_tog = 1;
        aw_pend = 0; w_pend = 0; aw_vec = '0; w_vec = '0; aw_cyc = 0; aw_wait = 0;
        forever begin
            @(negedge clk);
            if (!clr) begin
                pop_cmd = 0; pop_dat = 0; b_pend = 0; w_phase = 0;
                aw_pend = 0; w_pend = 0; aw_cyc = 0; aw_wait = 0;
            end else begin
                pop_cmd = bus.cmd_rd_en;
                pop_dat = bus.dat_rd_en;
                if (bus.cmd_rd_en) check("cmd_pop_nonempty", 64'(bus.cmd_empty), 64'd0);
                if (bus.dat_rd_en) check("dat_pop_nonempty", 64'(bus.dat_empty), 64'd0);
                aw_hs = bus.awvalid && bus.awready;
                w_hs  = bus.wvalid && bus.wready;
                b_hs  = bus.bvalid && bus.bready;
                if (aw_pend) check("aw_stable", 64'({bus.awvalid, bus.awaddr, bus.awlen}), 64'(aw_vec));
                if (bus.awvalid) aw_cyc++;
                if (aw_hs) begin
                    if (aw_exp.size() == 0) begin
                        check("aw_unexpected", 64'd1, 64'd0);
                    end else begin
                        ae = aw_exp.pop_front();
                        check("awaddr", 64'(bus.awaddr), 64'(ae.addr));
                        check("awlen", 64'(bus.awlen), 64'(ae.len));
                        check("aw_cycles", 64'(aw_cyc), 64'(ae.cycles));
                    end
                    aw_cyc  = 0;
                    w_phase = 1;
                end
                if (bus.wvalid) check("w_after_aw", 64'(w_phase), 64'd1);
                if (w_phase && !aw_hs) check("wvalid_vs_fifo", 64'(bus.wvalid), 64'(!bus.dat_empty));
                if (w_pend) check("w_stable", 64'({bus.wvalid, bus.wdata, bus.wlast}), 64'(w_vec));
                if (w_hs) begin
                    check("dat_rd_en", 64'(bus.dat_rd_en), 64'd1);
                    if (w_exp.size() == 0) begin
                        check("w_unexpected", 64'd1, 64'd0);
                    end else begin
                        we = w_exp.pop_front();
                        check("wdata", 64'(bus.wdata), 64'(we.data));
                        check("wlast", 64'(bus.wlast), 64'(we.last));
                    end
                    w_beats++;
                    if (bus.wlast) begin
                        w_phase = 0;
                        b_pend  = 1;
                    end
                end
                if (burst_done || b_hs) check("burst_done", 64'(burst_done), 64'(b_hs));
                if (b_hs) begin
                    if (b_exp.size() == 0) begin
                        check("b_unexpected", 64'd1, 64'd0);
                    end else begin
                        be = b_exp.pop_front();
                        check("resp_err", 64'(resp_err), 64'(be));
                    end
                end
                aw_pend = bus.awvalid && !aw_hs;
                aw_vec  = {bus.awvalid, bus.awaddr, bus.awlen};
                w_pend  = bus.wvalid && !w_hs;
                w_vec   = {bus.wvalid, bus.wdata, bus.wlast};
            end
            @(posedge clk);
            #1;
            if (pop_cmd && cmd_q.size() != 0) void'(cmd_q.pop_front());
            if (pop_dat && dat_q.size() != 0) void'(dat_q.pop_front());
            refresh();
            w_tog = !w_tog;
            bus.wready = wr_alt ? w_tog : 1'b1;
            if (!clr) begin
                bus.awready = 1'b0;
                bus.bvalid  = 1'b0;
            end else begin
                if (bus.awvalid) begin
                    bus.awready = (aw_wait >= aw_stall);
                    aw_wait++;
                end else begin
                    bus.awready = 1'b0;
                    aw_wait     = 0;
                end
                if (b_hs) bus.bvalid = 1'b0;
                if (b_pend && !bus.bvalid) begin
                    bus.bvalid = 1'b1;
                    bus.bresp  = (resp_q.size() != 0) ? resp_q.pop_front() : 2'b00;
                    b_pend     = 0;
                end
            end
        end
    end

    initial begin : main
        int cyc;
        int base;
        bus.awready = 0; bus.wready = 1; bus.bvalid = 0; bus.bresp = 2'b00;
        refresh();
        #1;
        check("rst_outputs", 64'({bus.awvalid, bus.wvalid, bus.bready, bus.cmd_rd_en,
                                  bus.dat_rd_en, busy, burst_done, resp_err}), 64'd0);
        check("rst_aw", 64'({bus.awaddr, bus.awlen}), 64'd0);
        check("awsize", 64'(bus.awsize), 64'd2);
        check("awburst", 64'(bus.awburst), 64'd1);
        check("wstrb", 64'(bus.wstrb), 64'hF);
        step();
        step();
        clr = 1'b1;
        step();

        // 1: single-beat burst, minimum latency
        push_burst(32'h1000, 8'd0, 32'hD000_0000, 2'b00);
        cyc = 0;
        do begin
            step();
            cyc++;
        end while (busy && cyc < 20);
        check("t1_latency", 64'(cyc), 64'd4);
        wait_done(20);

        // 2: alternating wready
        wr_alt = 1'b1;
        push_burst(32'h2000, 8'd3, 32'hA0, 2'b00);
        wait_done(60);
        wr_alt = 1'b0;

        // 3: data FIFO runs dry mid-burst
        push_cmd(32'h3000, 8'd3);
        push_data(32'hB0, 1'b0);
        push_data(32'hB1, 1'b0);
        push_resp(2'b00);
        for (int i = 0; i < 8; i++) step();
        check("t3_stalled_busy", 64'(busy), 64'd1);
        push_data(32'hB2, 1'b0);
        push_data(32'hB3, 1'b1);
        wait_done(40);

        // 4: AW back-pressure
        aw_stall = 6;
        push_burst(32'h4000, 8'd1, 32'hC0, 2'b00);
        wait_done(60);
        aw_stall = 0;

        // 5: error then okay response, two queued commands
        push_burst(32'h5000, 8'd1, 32'hE0, 2'b10);
        push_burst(32'h5100, 8'd2, 32'hF0, 2'b00);
        wait_done(80);

        // 6: reset mid-burst
        base = w_beats;
        push_burst(32'h6000, 8'd7, 32'h60, 2'b00);
        cyc = 0;
        while (w_beats - base < 2 && cyc < 40) begin
            step();
            cyc++;
        end
        check("t6_reach_beat2", 64'(cyc < 40), 64'd1);
        #1;
        clr = 1'b0;
        #1;
        check("t6_abort_outputs", 64'({bus.awvalid, bus.wvalid, bus.bready, bus.cmd_rd_en,
                                       bus.dat_rd_en, busy, burst_done, resp_err}), 64'd0);
        cmd_q.delete(); dat_q.delete(); resp_q.delete();
        aw_exp.delete(); w_exp.delete(); b_exp.delete();
        refresh();
        step();
        step();
        clr = 1'b1;
        step();
        check("t6_idle_after_clr", 64'(busy), 64'd0);
        push_burst(32'h7000, 8'd1, 32'h70, 2'b00);
        wait_done(40);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
